// File: rtl/cache_interface_types.sv
// Shared types for the cache port and its arbiter.
package cache_interface_types;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} cache_arb_state_t;

    // Map a requester index onto the state that grants it the port.
    function automatic cache_arb_state_t own_state(input logic n);
        return n ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/cache_interface.sv
// Core-to-cache request/response bundle. Master drives the request side.
interface cache_interface #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
);
    logic [ADDR_SIZE-1:0] addr;
    logic [1:0]           rd_size;
    logic [WORD_SIZE-1:0] wr_data;
    logic [1:0]           wr_size;
    logic                 write;
    logic                 access;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 hit;

    modport master (
        output addr, rd_size, wr_data, wr_size, write, access,
        input  rd_data, hit
    );

    modport slave (
        input  addr, rd_size, wr_data, wr_size, write, access,
        output rd_data, hit
    );
endinterface

// File: rtl/cache_port_mux.sv
// Combinational 2:1 steering of requester fields onto the shared cache port.
// While idle, select 0 is applied so the port carries requester 0's fields
// with access/write forced low.
module cache_port_mux #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
) (
    input  logic                 i_active,
    input  logic                 i_sel,
    input  logic [ADDR_SIZE-1:0] i_addr    [2],
    input  logic [1:0]           i_rd_size [2],
    input  logic [WORD_SIZE-1:0] i_wr_data [2],
    input  logic [1:0]           i_wr_size [2],
    input  logic                 i_write   [2],
    input  logic                 i_access  [2],
    input  logic                 i_mem_hit,
    output logic [ADDR_SIZE-1:0] o_addr,
    output logic [1:0]           o_rd_size,
    output logic [WORD_SIZE-1:0] o_wr_data,
    output logic [1:0]           o_wr_size,
    output logic                 o_write,
    output logic                 o_access,
    output logic [1:0]           o_hit
);

    // Forward the selected requester's fields; qualify the strobes by ownership.
    always_comb begin
        o_addr    = i_addr[i_sel];
        o_rd_size = i_rd_size[i_sel];
        o_wr_data = i_wr_data[i_sel];
        o_wr_size = i_wr_size[i_sel];
        o_write   = i_active & i_write[i_sel];
        o_access  = i_active & i_access[i_sel];
    end

    // Only the current owner sees the cache's hit.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit
            assign o_hit[gi] = i_active && (i_sel == 1'(gi)) && i_mem_hit;
        end
    endgenerate

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache port between instruction fetch
// (requester 0) and load/store (requester 1). A grant is held until the
// cache reports a hit, then handed straight to a waiting requester.
module cache_arbiter
    import cache_interface_types::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    cache_interface.slave        req0,
    cache_interface.slave        req1,
    cache_interface.master       mem,
    output logic                 busy_o,
    output logic                 grant_o,
    output logic [CNT_WIDTH-1:0] contention_cnt_o
);

    cache_arb_state_t     r_state;
    cache_arb_state_t     w_state_next;
    logic                 r_last;
    logic                 w_last_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;

    logic                 w_active;
    logic                 w_sel;
    logic                 w_owner_access;
    logic                 w_other_access;
    logic                 w_contend;
    logic [1:0]           w_hit;

    logic [ADDR_SIZE-1:0] w_addr    [2];
    logic [1:0]           w_rd_size [2];
    logic [WORD_SIZE-1:0] w_wr_data [2];
    logic [1:0]           w_wr_size [2];
    logic                 w_write   [2];
    logic                 w_access  [2];

    assign w_addr[0]    = req0.addr;
    assign w_addr[1]    = req1.addr;
    assign w_rd_size[0] = req0.rd_size;
    assign w_rd_size[1] = req1.rd_size;
    assign w_wr_data[0] = req0.wr_data;
    assign w_wr_data[1] = req1.wr_data;
    assign w_wr_size[0] = req0.wr_size;
    assign w_wr_size[1] = req1.wr_size;
    assign w_write[0]   = req0.write;
    assign w_write[1]   = req1.write;
    assign w_access[0]  = req0.access;
    assign w_access[1]  = req1.access;

    // State, last winner and contention count; reset leaves last=1 so req0 wins the first tie.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state: pick a winner from idle, hand over on a hit, drop to idle on withdrawal.
    always_comb begin
        w_state_next   = r_state;
        w_last_next    = r_last;
        w_owner_access = w_sel ? req1.access : req0.access;
        w_other_access = w_sel ? req0.access : req1.access;
        w_contend      = (req0.access && (r_state != ARB_OWN0)) ||
                         (req1.access && (r_state != ARB_OWN1));
        w_cnt_next     = w_contend ? r_cnt + CNT_WIDTH'(1) : r_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (req0.access && req1.access) begin
                    w_state_next = own_state(~r_last);
                end else if (req0.access) begin
                    w_state_next = ARB_OWN0;
                end else if (req1.access) begin
                    w_state_next = ARB_OWN1;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (w_owner_access && mem.hit) begin
                    w_last_next = w_sel;
                    if (w_other_access) begin
                        w_state_next = own_state(~w_sel);
                    end
                end else if (!w_owner_access) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    // Outputs decoded from the held state only.
    always_comb begin
        w_active = (r_state != ARB_IDLE);
        w_sel    = (r_state == ARB_OWN1);
        busy_o   = w_active;
        grant_o  = w_sel;
    end

    cache_port_mux #(
        .ADDR_SIZE (ADDR_SIZE),
        .WORD_SIZE (WORD_SIZE)
    ) u_mux (
        .i_active  (w_active),
        .i_sel     (w_sel),
        .i_addr    (w_addr),
        .i_rd_size (w_rd_size),
        .i_wr_data (w_wr_data),
        .i_wr_size (w_wr_size),
        .i_write   (w_write),
        .i_access  (w_access),
        .i_mem_hit (mem.hit),
        .o_addr    (mem.addr),
        .o_rd_size (mem.rd_size),
        .o_wr_data (mem.wr_data),
        .o_wr_size (mem.wr_size),
        .o_write   (mem.write),
        .o_access  (mem.access),
        .o_hit     (w_hit)
    );

    assign req0.hit         = w_hit[0];
    assign req1.hit         = w_hit[1];
    // Read data is broadcast; each requester qualifies it with its own hit.
    assign req0.rd_data     = mem.rd_data;
    assign req1.rd_data     = mem.rd_data;
    assign contention_cnt_o = r_cnt;

endmodule
